// File: rtl/vdma_pkg.sv
// rtl/vdma_pkg.sv - shared VDMA helpers: one-hot pointer decode and frame-sync edge names
//
// Purpose : common constants and pure functions used by the VDMA frame-buffer
//           selectors. No ports; import with "import vdma_pkg::*".
// Contents: VS_RISING / VS_FALLING  - legal values of the VS_EDGE parameter
//           PTR_MAX_W               - widest one-hot pointer the helpers accept
//           onehot2idx()            - priority encoder, lowest set bit wins
//           is_onehot()             - true when exactly one bit is set
package vdma_pkg;

   localparam string VS_RISING  = "RISING";
   localparam string VS_FALLING = "FALLING";

   localparam int PTR_MAX_W = 16;

   // Callers zero-extend their pointer to PTR_MAX_W bits. For a legal one-hot
   // pointer the encoder priority is irrelevant; it only fixes the result
   // deterministically for the illegal patterns.
   function automatic logic [3:0] onehot2idx(input logic [PTR_MAX_W-1:0] ptr);
      logic [3:0] idx;
      idx = '0;
      for (int i = PTR_MAX_W - 1; i >= 0; i--) begin
         if (ptr[i]) begin
            idx = 4'(i);
         end
      end
      return idx;
   endfunction

   // Clearing the lowest set bit leaves zero only for a single-bit pattern.
   function automatic logic is_onehot(input logic [PTR_MAX_W-1:0] ptr);
      return (ptr != '0) && ((ptr & (ptr - PTR_MAX_W'(1))) == '0);
   endfunction

endpackage

// File: rtl/vs_edge_det.sv
// rtl/vs_edge_det.sv - frame-sync edge detector with optional input synchronizer
//
// Purpose : turns the level vsync into a single-cycle event on the selected
//           edge. Macro RD_BASE_SYNC_EN inserts a 2-flop synchronizer in front
//           of the detector for a vsync that is asynchronous to rclk.
// Ports   : rclk    in  read-domain clock
//           rd_rst  in  synchronous active-high reset (all flops clear to 0)
//           vsync   in  frame sync level
//           vs_evt  out event, high for one cycle after the selected edge
module vs_edge_det
   import vdma_pkg::*;
#(
   parameter string VS_EDGE = VS_RISING
) (
   input  logic rclk,
   input  logic rd_rst,
   input  logic vsync,
   output logic vs_evt
);

   localparam bit FALL_EDGE = (VS_EDGE == VS_FALLING);

   logic vs_in;

`ifdef RD_BASE_SYNC_EN
   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;

   always_comb begin
      sync1_d = vsync;
      sync2_d = sync1_q;
   end

   always_ff @(posedge rclk) begin
      if (rd_rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign vs_in = sync2_q;
`else
   assign vs_in = vsync;
`endif

   logic vs_r1_q, vs_r1_d;
   logic vs_r2_q, vs_r2_d;

   always_comb begin
      vs_r1_d = vs_in;
      vs_r2_d = vs_r1_q;
   end

   // Clearing to 0 means a vsync already high at reset release is seen as
   // a fresh rising edge.
   always_ff @(posedge rclk) begin
      if (rd_rst) begin
         vs_r1_q <= 1'b0;
         vs_r2_q <= 1'b0;
      end else begin
         vs_r1_q <= vs_r1_d;
         vs_r2_q <= vs_r2_d;
      end
   end

   always_comb begin
      vs_evt = FALL_EDGE ? (~vs_r1_q & vs_r2_q) : (vs_r1_q & ~vs_r2_q);
   end

endmodule

// File: rtl/rd_base_sel.sv
// rtl/rd_base_sel.sv - VDMA read-side frame-buffer selector and base-address generator
//
// Purpose : on every frame-sync event, switch the read buffer to the one the
//           writer last completed, unless frozen, the pointer is not one-hot,
//           or the writer is still filling it. Produces the buffer index and
//           the byte base address for the read address generator.
// Config  : RD_BASE_SYNC_EN (macro) adds a 2-flop vsync synchronizer, +2 cycles.
// Ports   : rclk             in  read-domain clock
//           rd_rst           in  synchronous active-high reset
//           vsync            in  read frame sync, level
//           last_next_point  in  one-hot, writer's last completed buffer
//           wr_curr_point    in  one-hot, buffer the writer is filling
//           freeze           in  hold the current buffer across events
//           rd_curr_point    out one-hot current read buffer
//           rd_index         out binary index of rd_curr_point
//           rd_base_addr     out BASE_ADDR + rd_index*FRAME_BYTES
//           rd_base_vld      out pulse, rd_base_addr refreshed by a load
//           err_collision    out pulse, switch refused: buffer being written
//           err_onehot       out pulse, switch refused: pointer not one-hot
module rd_base_sel
   import vdma_pkg::*;
#(
   parameter int                NUM_BUF     = 5,
   parameter int                RST_IDX     = 1,
   parameter int                ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
   parameter logic [ADDR_W-1:0] FRAME_BYTES = ADDR_W'(32'h0080_0000),
   parameter string             VS_EDGE     = VS_RISING
) (
   input  logic                       rclk,
   input  logic                       rd_rst,
   input  logic                       vsync,
   input  logic [NUM_BUF-1:0]         last_next_point,
   input  logic [NUM_BUF-1:0]         wr_curr_point,
   input  logic                       freeze,
   output logic [NUM_BUF-1:0]         rd_curr_point,
   output logic [$clog2(NUM_BUF)-1:0] rd_index,
   output logic [ADDR_W-1:0]          rd_base_addr,
   output logic                       rd_base_vld,
   output logic                       err_collision,
   output logic                       err_onehot
);

   localparam int IDX_W = $clog2(NUM_BUF);

   localparam logic [NUM_BUF-1:0] RST_PTR   = NUM_BUF'(1) << RST_IDX;
   localparam logic [IDX_W-1:0]   RST_INDEX = IDX_W'(RST_IDX);
   localparam logic [ADDR_W-1:0]  RST_ADDR  = BASE_ADDR + ADDR_W'(RST_IDX) * FRAME_BYTES;

   logic vs_evt;

   vs_edge_det #(
      .VS_EDGE (VS_EDGE)
   ) u_vs_edge_det (
      .rclk   (rclk),
      .rd_rst (rd_rst),
      .vsync  (vsync),
      .vs_evt (vs_evt)
   );

   logic [NUM_BUF-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               load_q, load_d;
   logic               err_col_q, err_col_d;
   logic               err_oh_q, err_oh_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic               vld_q, vld_d;

   logic [PTR_MAX_W-1:0] lnp_ext;
   assign lnp_ext = PTR_MAX_W'(last_next_point);

   // Decision stage: freeze outranks the one-hot check, which outranks the
   // collision check, so an illegal pointer is never compared to the writer.
   always_comb begin
      ptr_d     = ptr_q;
      idx_d     = idx_q;
      load_d    = 1'b0;
      err_col_d = 1'b0;
      err_oh_d  = 1'b0;
      if (vs_evt && !freeze) begin
         if (!is_onehot(lnp_ext)) begin
            err_oh_d = 1'b1;
         end else if (last_next_point == wr_curr_point) begin
            err_col_d = 1'b1;
         end else begin
            ptr_d  = last_next_point;
            idx_d  = IDX_W'(onehot2idx(lnp_ext));
            load_d = 1'b1;
         end
      end
   end

   // Address stage: one cycle behind the pointer so the multiply sits alone
   // between registers. A reload to the same buffer still pulses rd_base_vld.
   always_comb begin
      addr_d = addr_q;
      vld_d  = load_q;
      if (load_q) begin
         addr_d = BASE_ADDR + ADDR_W'(idx_q) * FRAME_BYTES;
      end
   end

   always_ff @(posedge rclk) begin
      if (rd_rst) begin
         ptr_q     <= RST_PTR;
         idx_q     <= RST_INDEX;
         load_q    <= 1'b0;
         err_col_q <= 1'b0;
         err_oh_q  <= 1'b0;
         addr_q    <= RST_ADDR;
         vld_q     <= 1'b0;
      end else begin
         ptr_q     <= ptr_d;
         idx_q     <= idx_d;
         load_q    <= load_d;
         err_col_q <= err_col_d;
         err_oh_q  <= err_oh_d;
         addr_q    <= addr_d;
         vld_q     <= vld_d;
      end
   end

   assign rd_curr_point = ptr_q;
   assign rd_index      = idx_q;
   assign rd_base_addr  = addr_q;
   assign rd_base_vld   = vld_q;
   assign err_collision = err_col_q;
   assign err_onehot    = err_oh_q;

endmodule

// File: tb/tb_rd_base_sel.sv
// tb/tb_rd_base_sel.sv - self-checking bench for rd_base_sel (rising and falling builds)
module tb_rd_base_sel;

`ifdef RD_BASE_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   localparam logic [31:0] FB = 32'h0080_0000;

   logic        rclk = 1'b0;
   logic        rd_rst = 1'b0;
   logic        vsync = 1'b0;
   logic [4:0]  last_next_point = '0;
   logic [4:0]  wr_curr_point = '0;
   logic        freeze = 1'b0;

   logic [4:0]  rd_curr_point, f_rd_curr_point;
   logic [2:0]  rd_index, f_rd_index;
   logic [31:0] rd_base_addr, f_rd_base_addr;
   logic        rd_base_vld, f_rd_base_vld;
   logic        err_collision, f_err_collision;
   logic        err_onehot, f_err_onehot;

   int n_checks = 0;
   int n_fail = 0;
   logic [4:0] exp_ptr = 5'b00010;

   always #5 rclk = ~rclk;

   rd_base_sel #(
      .NUM_BUF(5), .RST_IDX(1), .ADDR_W(32), .BASE_ADDR(32'h0),
      .FRAME_BYTES(32'h0080_0000), .VS_EDGE("RISING")
   ) dut (
      .rclk(rclk), .rd_rst(rd_rst), .vsync(vsync),
      .last_next_point(last_next_point), .wr_curr_point(wr_curr_point), .freeze(freeze),
      .rd_curr_point(rd_curr_point), .rd_index(rd_index), .rd_base_addr(rd_base_addr),
      .rd_base_vld(rd_base_vld), .err_collision(err_collision), .err_onehot(err_onehot)
   );

   rd_base_sel #(
      .NUM_BUF(5), .RST_IDX(1), .ADDR_W(32), .BASE_ADDR(32'h0),
      .FRAME_BYTES(32'h0080_0000), .VS_EDGE("FALLING")
   ) dut_f (
      .rclk(rclk), .rd_rst(rd_rst), .vsync(vsync),
      .last_next_point(last_next_point), .wr_curr_point(wr_curr_point), .freeze(freeze),
      .rd_curr_point(f_rd_curr_point), .rd_index(f_rd_index), .rd_base_addr(f_rd_base_addr),
      .rd_base_vld(f_rd_base_vld), .err_collision(f_err_collision), .err_onehot(f_err_onehot)
   );

   typedef struct packed {
      logic [4:0]  p1;
      logic [2:0]  i1;
      logic        eo1;
      logic        ec1;
      logic        v1;
      logic [31:0] a2;
      logic        v2;
      logic [4:0]  pend;
      logic [7:0]  n_vld;
      logic [7:0]  n_eo;
      logic [7:0]  n_ec;
   } sample_t;

   function automatic string fmt(input sample_t s);
      return $sformatf("p1=%b i1=%0d eo1=%b ec1=%b v1=%b a2=%h v2=%b pend=%b nvld=%0d neo=%0d nec=%0d",
                       s.p1, s.i1, s.eo1, s.ec1, s.v1, s.a2, s.v2, s.pend, s.n_vld, s.n_eo, s.n_ec);
   endfunction

   function automatic sample_t mk(input logic [4:0] p1, input logic [2:0] i1, input logic eo1,
                                  input logic ec1, input logic [31:0] a2, input logic v2);
      sample_t s;
      s = '0;
      s.p1 = p1; s.i1 = i1; s.eo1 = eo1; s.ec1 = ec1; s.a2 = a2; s.v2 = v2;
      s.pend = p1; s.n_vld = {7'd0, v2}; s.n_eo = {7'd0, eo1}; s.n_ec = {7'd0, ec1};
      return s;
   endfunction

   function automatic int idx_of(input logic [4:0] p);
      int r;
      r = 0;
      for (int i = 0; i < 5; i++) if (p[i]) r = i;
      return r;
   endfunction

   // Reference model: outcome of one frame-sync event from the selection rules.
   function automatic sample_t predict(input logic [4:0] cur, input logic [4:0] lnp,
                                       input logic [4:0] wcp, input logic frz);
      logic [4:0] nxt;
      logic eo, ec, ld;
      nxt = cur; eo = 1'b0; ec = 1'b0; ld = 1'b0;
      if (!frz) begin
         if ($countones(lnp) != 1) eo = 1'b1;
         else if (lnp == wcp) ec = 1'b1;
         else begin nxt = lnp; ld = 1'b1; end
      end
      return mk(nxt, 3'(idx_of(nxt)), eo, ec, 32'(idx_of(nxt)) * FB, ld);
   endfunction

   // Drive one vsync pulse (hi cycles high, then lo cycles low) and sample.
   // Edge 0 is the first edge that sees vsync high.
   task automatic do_event(input logic [4:0] lnp, input logic [4:0] wcp, input logic frz,
                           input int hi, input int lo, input bit scramble, output sample_t s);
      s = '0;
      @(negedge rclk);
      last_next_point = lnp; wr_curr_point = wcp; freeze = frz; vsync = 1'b1;
      for (int e = 0; e < hi + lo; e++) begin
         @(posedge rclk); #1;
         if (rd_base_vld)   s.n_vld = s.n_vld + 8'd1;
         if (err_onehot)    s.n_eo = s.n_eo + 8'd1;
         if (err_collision) s.n_ec = s.n_ec + 8'd1;
         if (e == LAT + 1) begin
            s.p1 = rd_curr_point; s.i1 = rd_index; s.eo1 = err_onehot;
            s.ec1 = err_collision; s.v1 = rd_base_vld;
         end
         if (e == LAT + 2) begin
            s.a2 = rd_base_addr; s.v2 = rd_base_vld;
         end
         if (e == hi - 1 || (scramble && e == LAT + 2)) begin
            @(negedge rclk);
            if (e == hi - 1) vsync = 1'b0;
            if (scramble && e == LAT + 2) begin
               last_next_point = 5'($urandom); wr_curr_point = 5'($urandom);
               freeze = 1'($urandom);
            end
         end
      end
      s.pend = rd_curr_point;
   endtask

   task automatic test_reset();
      logic [42:0] got;
      vsync = 1'b0; freeze = 1'b0; last_next_point = '0; wr_curr_point = '0;
      @(negedge rclk); rd_rst = 1'b1;
      repeat (3) @(posedge rclk);
      #1;
      got = {rd_curr_point, rd_index, rd_base_addr, rd_base_vld, err_collision, err_onehot};
      n_checks++;
      if (got !== {5'b00010, 3'd1, 32'h0080_0000, 3'b000}) begin
         n_fail++; $display("FAIL reset_during: got %h exp %h", got, {5'b00010, 3'd1, 32'h0080_0000, 3'b000});
      end
      @(negedge rclk); rd_rst = 1'b0;
      repeat (2) @(posedge rclk);
      #1;
      got = {rd_curr_point, rd_index, rd_base_addr, rd_base_vld, err_collision, err_onehot};
      n_checks++;
      if (got !== {5'b00010, 3'd1, 32'h0080_0000, 3'b000}) begin
         n_fail++; $display("FAIL reset_after: got %h exp %h", got, {5'b00010, 3'd1, 32'h0080_0000, 3'b000});
      end
      exp_ptr = 5'b00010;
   endtask

   task automatic test_normal();
      sample_t s, e;
      do_event(5'b01000, 5'b00001, 1'b0, 3, LAT + 4, 1'b0, s);
      e = mk(5'b01000, 3'd3, 1'b0, 1'b0, 32'h0180_0000, 1'b1);
      n_checks++;
      if (s !== e) begin n_fail++; $display("FAIL normal: got %s exp %s", fmt(s), fmt(e)); end
      exp_ptr = 5'b01000;
   endtask

   task automatic test_collision();
      sample_t s, e;
      do_event(5'b00100, 5'b00100, 1'b0, 2, LAT + 4, 1'b1, s);
      e = mk(5'b01000, 3'd3, 1'b0, 1'b1, 32'h0180_0000, 1'b0);
      n_checks++;
      if (s !== e) begin n_fail++; $display("FAIL collision: got %s exp %s", fmt(s), fmt(e)); end
   endtask

   task automatic test_bad_ptr();
      sample_t s, e;
      do_event(5'b00110, 5'b00001, 1'b0, 2, LAT + 4, 1'b0, s);
      e = mk(5'b01000, 3'd3, 1'b1, 1'b0, 32'h0180_0000, 1'b0);
      n_checks++;
      if (s !== e) begin n_fail++; $display("FAIL bad_ptr_multi: got %s exp %s", fmt(s), fmt(e)); end
      do_event(5'b00000, 5'b00001, 1'b0, 2, LAT + 4, 1'b0, s);
      n_checks++;
      if (s !== e) begin n_fail++; $display("FAIL bad_ptr_zero: got %s exp %s", fmt(s), fmt(e)); end
   endtask

   task automatic test_freeze();
      sample_t s, e;
      e = mk(5'b01000, 3'd3, 1'b0, 1'b0, 32'h0180_0000, 1'b0);
      for (int n = 0; n < 3; n++) begin
         do_event(5'b10000, 5'b00001, 1'b1, 2, LAT + 4, 1'b1, s);
         n_checks++;
         if (s !== e) begin n_fail++; $display("FAIL freeze_%0d: got %s exp %s", n, fmt(s), fmt(e)); end
      end
      do_event(5'b10000, 5'b00001, 1'b0, 2, LAT + 4, 1'b0, s);
      e = mk(5'b10000, 3'd4, 1'b0, 1'b0, 32'h0200_0000, 1'b1);
      n_checks++;
      if (s !== e) begin n_fail++; $display("FAIL freeze_release: got %s exp %s", fmt(s), fmt(e)); end
      exp_ptr = 5'b10000;
   endtask

   task automatic test_hold_high();
      sample_t s, e;
      do_event(5'b00001, 5'b00010, 1'b0, 100, LAT + 4, 1'b1, s);
      e = mk(5'b00001, 3'd0, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
      n_checks++;
      if (s !== e) begin n_fail++; $display("FAIL hold_high: got %s exp %s", fmt(s), fmt(e)); end
      exp_ptr = 5'b00001;
   endtask

   task automatic test_random();
      for (int n = 0; n < 24; n++) begin
         logic [4:0] lnp, wcp;
         logic frz;
         int hi, lo;
         sample_t s, e;
         wcp = 5'(1 << $urandom_range(4, 0));
         case ($urandom_range(9, 0))
            0, 1:    lnp = 5'($urandom);
            2, 3:    lnp = wcp;
            default: lnp = 5'(1 << $urandom_range(4, 0));
         endcase
         frz = ($urandom_range(4, 0) == 0);
         hi = $urandom_range(6, 1);
         lo = LAT + $urandom_range(6, 3);
         e = predict(exp_ptr, lnp, wcp, frz);
         do_event(lnp, wcp, frz, hi, lo, 1'b1, s);
         n_checks++;
         if (s !== e) begin
            n_fail++; $display("FAIL random_%0d lnp=%b wcp=%b frz=%b: got %s exp %s", n, lnp, wcp, frz, fmt(s), fmt(e));
         end
         exp_ptr = e.pend;
      end
   endtask

   task automatic test_reset_mid();
      logic [4:0] lnp;
      logic [42:0] got;
      logic [42:0] rst_vals;
      rst_vals = {5'b00010, 3'd1, 32'h0080_0000, 3'b000};
      lnp = (exp_ptr == 5'b00100) ? 5'b01000 : 5'b00100;
      @(negedge rclk);
      last_next_point = lnp; wr_curr_point = 5'b10000; freeze = 1'b0; vsync = 1'b1;
      repeat (LAT + 1) @(negedge rclk);
      rd_rst = 1'b1;
      @(posedge rclk); #1;
      got = {rd_curr_point, rd_index, rd_base_addr, rd_base_vld, err_collision, err_onehot};
      n_checks++;
      if (got !== rst_vals) begin n_fail++; $display("FAIL reset_mid_edge: got %h exp %h", got, rst_vals); end
      @(negedge rclk); rd_rst = 1'b0;
      for (int e = 0; e <= LAT + 2; e++) begin
         @(posedge rclk); #1;
         got = {rd_curr_point, rd_index, rd_base_addr, rd_base_vld, err_collision, err_onehot};
         if (e == LAT) begin
            n_checks++;
            if (got !== rst_vals) begin n_fail++; $display("FAIL reset_mid_hold: got %h exp %h", got, rst_vals); end
         end
         if (e == LAT + 1) begin
            n_checks++;
            if (rd_curr_point !== lnp) begin
               n_fail++; $display("FAIL reset_mid_reload: got %b exp %b", rd_curr_point, lnp);
            end
         end
         if (e == LAT + 2) begin
            n_checks++;
            if ({rd_base_addr, rd_base_vld} !== {32'(idx_of(lnp)) * FB, 1'b1}) begin
               n_fail++; $display("FAIL reset_mid_addr: got %h/%b exp %h/1", rd_base_addr, rd_base_vld, 32'(idx_of(lnp)) * FB);
            end
         end
      end
      @(negedge rclk); vsync = 1'b0;
      repeat (LAT + 4) @(posedge rclk);
      exp_ptr = lnp;
   endtask

   task automatic test_falling();
      int f_vld, r_vld;
      logic [4:0] f_p;
      logic [31:0] f_a;
      logic f_v;
      @(negedge rclk); rd_rst = 1'b1; vsync = 1'b0;
      repeat (2) @(posedge rclk);
      @(negedge rclk); rd_rst = 1'b0;
      last_next_point = 5'b00100; wr_curr_point = 5'b00001; freeze = 1'b0;
      repeat (2) @(posedge rclk);
      @(negedge rclk); vsync = 1'b1;
      f_vld = 0;
      for (int e = 0; e < LAT + 5; e++) begin
         @(posedge rclk); #1;
         if (f_rd_base_vld) f_vld++;
      end
      n_checks++;
      if ({f_rd_curr_point, f_vld[7:0]} !== {5'b00010, 8'd0}) begin
         n_fail++; $display("FAIL falling_on_rise: got ptr=%b vld=%0d exp ptr=00010 vld=0", f_rd_curr_point, f_vld);
      end
      n_checks++;
      if (rd_curr_point !== 5'b00100) begin
         n_fail++; $display("FAIL rising_on_rise: got %b exp 00100", rd_curr_point);
      end
      @(negedge rclk); vsync = 1'b0;
      f_vld = 0; r_vld = 0; f_p = '0; f_a = '0; f_v = 1'b0;
      for (int e = 0; e < LAT + 5; e++) begin
         @(posedge rclk); #1;
         if (f_rd_base_vld) f_vld++;
         if (rd_base_vld) r_vld++;
         if (e == LAT + 1) f_p = f_rd_curr_point;
         if (e == LAT + 2) begin f_a = f_rd_base_addr; f_v = f_rd_base_vld; end
      end
      n_checks++;
      if ({f_p, f_a, f_v, f_vld[7:0]} !== {5'b00100, 32'h0100_0000, 1'b1, 8'd1}) begin
         n_fail++; $display("FAIL falling_on_fall: got ptr=%b addr=%h vld=%b n=%0d exp ptr=00100 addr=01000000 vld=1 n=1",
                            f_p, f_a, f_v, f_vld);
      end
      n_checks++;
      if ({rd_curr_point, r_vld[7:0]} !== {5'b00100, 8'd0}) begin
         n_fail++; $display("FAIL rising_on_fall: got ptr=%b vld=%0d exp ptr=00100 vld=0", rd_curr_point, r_vld);
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_collision();
      test_bad_ptr();
      test_freeze();
      test_hold_high();
      test_random();
      test_reset_mid();
      test_falling();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rd_base_sel.md
# rd_base_sel

Read-side frame-buffer selector for the VDMA read channel. It tracks which of `NUM_BUF` frame buffers the read master scans out and switches buffers on each frame-sync edge, taking the buffer the writer last completed. The switch is suppressed if that buffer is still being written, and it can be frozen by software. It converts the one-hot buffer pointer into a buffer index and a byte base address for the read address generator.

## Interface
Parameters:
- `NUM_BUF`, 5: number of frame buffers; pointer width (2..16).
- `RST_IDX`, 1: buffer index selected after reset.
- `ADDR_W`, 32: base-address width.
- `BASE_ADDR`, 32'h0000_0000: byte address of buffer 0.
- `FRAME_BYTES`, 32'h0080_0000: byte stride between buffers.
- `VS_EDGE`, "RISING": frame-sync edge, either "RISING" or "FALLING".

Ports:
- `rclk`  in  1: read-domain clock. Single clock for the whole block.
- `rd_rst`  in  1: reset, synchronous and active-high.
- `vsync`  in  1: read frame sync, level.
- `last_next_point`  in  NUM_BUF: one-hot pointer to the writer's last completed buffer.
- `wr_curr_point`  in  NUM_BUF: one-hot pointer to the buffer the writer is filling now.
- `freeze`  in  1: when high, hold the current buffer across frame-sync edges.
- `rd_curr_point`  out  NUM_BUF: one-hot current read buffer.
- `rd_index`  out  $clog2(NUM_BUF): binary index of `rd_curr_point`.
- `rd_base_addr`  out  ADDR_W: `BASE_ADDR + rd_index*FRAME_BYTES`.
- `rd_base_vld`  out  1: one-cycle pulse when `rd_base_addr` has been refreshed.
- `err_collision`  out  1: one-cycle pulse when a switch was refused because of a collision.
- `err_onehot`  out  1: one-cycle pulse when a switch was refused because `last_next_point` was not one-hot.

## Operation
Reset values:
- `rd_curr_point` = 1<<RST_IDX.
- `rd_index` = RST_IDX.
- `rd_base_addr` = BASE_ADDR + RST_IDX*FRAME_BYTES.
- All pulse outputs = 0.

Edge detect:
- `vsync` is registered twice (`vs_r1`, `vs_r2`).
- For "RISING", `vs_evt = vs_r1 & ~vs_r2`; for "FALLING", `vs_evt = ~vs_r1 & vs_r2`.

Decision on `vs_evt`, evaluated in this priority order:
1. `freeze` = 1: hold the pointer; no pulses.
2. `last_next_point` is zero or has more than one bit set: hold; pulse `err_onehot`.
3. `last_next_point == wr_curr_point`: hold; pulse `err_collision`.
4. Otherwise load `last_next_point` into `rd_curr_point`. `rd_index` is updated on the same edge from a priority encoder applied to `last_next_point`.

Address stage:
- One pipeline register computes `rd_base_addr` from `rd_index`.
- `rd_base_vld` pulses on every accepted load (case 4), including when the new pointer equals the old one.
- Refused or frozen events produce no `rd_base_vld`.
- The multiply is a constant multiply truncated to ADDR_W; wrap-around beyond 2^ADDR_W is not checked.

Other rules:
- Without `vs_evt`, all state holds and all pulses are 0. Changes on `last_next_point`, `wr_curr_point` and `freeze` have no effect between events.
- Reset asserted mid-operation wins on the same edge. Edge-detect registers clear to 0, so a `vsync` that is already high when reset releases produces a `vs_evt` ("RISING") two edges later.

## Timing
- `vsync` first sampled high at edge k (RISING): `vs_evt` is high during cycle k..k+1.
- `rd_curr_point`, `rd_index`, `err_*` update at edge k+1.
- `rd_base_addr` and `rd_base_vld` update at edge k+2.
- Added latency with `RD_BASE_SYNC_EN` defined: +2 cycles on all of the above.
- Back-to-back events must be at least 2 cycles apart; a `vsync` held high produces exactly one event.

## Configuration
- `RD_BASE_SYNC_EN` defined: `vsync` passes through a 2-flop metastability synchronizer ahead of the edge detector. Use this when `vsync` originates outside the `rclk` domain. The synchronizer flops reset to 0.
- `RD_BASE_SYNC_EN` undefined: `vsync` is treated as `rclk`-synchronous and feeds `vs_r1` directly.

## Structure
- The shared package `vdma_pkg` holds `onehot2idx`, `is_onehot`, and the `VS_EDGE` string constants.
- Sub-module `vs_edge_det` covers the optional synchronizer, the two-register edge detector and edge selection, and outputs `vs_evt`. The pointer, decision and address logic stays in the top module.

## Test plan
All cases use NUM_BUF=5, BASE=0, FRAME_BYTES=0x800000.
- Reset: `rd_rst` high 3 cycles → `rd_curr_point`=5'b00010, `rd_index`=1, `rd_base_addr`=0x800000, no pulses.
- Normal switch: `last_next_point`=5'b01000, `wr_curr_point`=5'b00001, `vsync` rises → `rd_curr_point`=5'b01000 at k+1; `rd_base_addr`=0x1800000 and `rd_base_vld` at k+2.
- Collision: `last_next_point` = `wr_curr_point` = 5'b00100 → pointer holds; `err_collision` pulses once at k+1; no `rd_base_vld`.
- Bad pointer: `last_next_point`=5'b00110, then 5'b00000 → hold; `err_onehot` pulses for each event.
- Freeze: `freeze`=1 across 3 `vsync` events → pointer unchanged; no pulses. Release, next event → normal load.
- Edge cases:
  - FALLING build: the switch happens on the `vsync` fall only.
  - `vsync` held high 100 cycles → one event.
  - Reset asserted on the edge where `vs_evt` is high → reset values win.
